// File: rtl/boot_loader_mem_pkg.sv
// Shared definitions for the boot loader memory: memory geometry and the
// loader FSM state encoding.
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN (S_CSUM / S_ERR are only
// reachable when it is defined; the encodings exist in both builds).
package boot_loader_mem_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 16;

   typedef enum logic [2:0] {
      S_LEN  = 3'd0,
      S_HI   = 3'd1,
      S_LO   = 3'd2,
      S_CSUM = 3'd3,
      S_RUN  = 3'd4,
      S_ERR  = 3'd5
   } state_t;

endpackage

// File: rtl/boot_loader_mem_sp_ram_rf.sv
// sp_ram_rf: read-first synchronous RAM with one write port and one
// registered read port. Array contents are never reset; only the read
// register is.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  registered read data, old contents on a same-address write
module sp_ram_rf #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata <= '0;
      else     rdata <= mem[raddr];
   end

endmodule

// File: rtl/boot_loader_mem.sv
// boot_loader_mem: unified program/data memory with a byte-serial program
// loader. Holds the CPU in reset while an image is streamed in from address
// 0, then releases it.
//
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte; a mismatch parks the FSM in S_ERR with load_err set.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cpu_addr/cpu_wdata   CPU address and write data
//   cpu_wea              CPU write enable (honoured only while running)
//   cpu_rdata            registered read data (1-cycle latency)
//   cpu_hold             1 = CPU held in reset
//   ld_byte/ld_valid     loader byte stream
//   ld_ready             loader byte accepted this cycle (state-only)
//   load_done            image loaded, CPU running
//   load_err             checksum failure (0 without the feature)
//   word_count           words written by the current load
//
// state  | meaning
// S_LEN  | waiting for length byte (0 = full depth)
// S_HI   | waiting for high byte of next word
// S_LO   | waiting for low byte; word written on acceptance
// S_CSUM | waiting for checksum byte (feature only)
// S_RUN  | image loaded, CPU released
// S_ERR  | checksum mismatch, CPU kept in reset (feature only)
module boot_loader_mem
   import boot_loader_mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_wea,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hold,
   input  logic [7:0]        ld_byte,
   input  logic              ld_valid,
   output logic              ld_ready,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   state_t              state, state_next;
   logic [ADDR_W:0]     remaining;
   logic [DATA_W-9:0]   hi;
   logic [ADDR_W-1:0]   wptr;
   logic                xfer;
   logic                ld_we;
   logic                cpu_we;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [DATA_W-1:0]   ram_wdata;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]          csum;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_LEN;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      ld_ready   = 1'b0;
      ld_we      = 1'b0;
      case (state)
         S_LEN: begin
            ld_ready = 1'b1;
            if (ld_valid) state_next = S_HI;
         end
         S_HI: begin
            ld_ready = 1'b1;
            if (ld_valid) state_next = S_LO;
         end
         S_LO: begin
            ld_ready = 1'b1;
            if (ld_valid) begin
               ld_we = 1'b1;
               if (remaining == (ADDR_W+1)'(1)) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                  state_next = S_CSUM;
`else
                  state_next = S_RUN;
`endif
               end else begin
                  state_next = S_HI;
               end
            end
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         S_CSUM: begin
            ld_ready = 1'b1;
            if (ld_valid) state_next = (ld_byte == csum) ? S_RUN : S_ERR;
         end
`endif
         default: begin
            state_next = state;
         end
      endcase
   end

   assign xfer = ld_valid & ld_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining  <= '0;
         hi         <= '0;
         wptr       <= '0;
         word_count <= '0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
      end else begin
         if (xfer && state == S_LEN)
            remaining <= (ld_byte == 8'd0) ? (ADDR_W+1)'(2**ADDR_W)
                                           : (ADDR_W+1)'(ld_byte);
         if (xfer && state == S_HI) hi <= ld_byte;
         if (ld_we) begin
            wptr       <= wptr + 1'b1;
            word_count <= word_count + 1'b1;
            remaining  <= remaining - 1'b1;
         end
         // Registered from state so the CPU sees release one cycle after entry.
         cpu_hold  <= (state != S_RUN);
         load_done <= (state == S_RUN);
      end
   end

`ifdef BOOT_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         csum     <= '0;
         load_err <= 1'b0;
      end else begin
         if (xfer && (state == S_HI || state == S_LO)) csum <= csum ^ ld_byte;
         load_err <= (state == S_ERR);
      end
   end
`else
   assign load_err = 1'b0;
`endif

   // Loader owns the write port until release; the CPU write is also gated by
   // cpu_hold so the entry cycle of S_RUN cannot sneak a write through.
   assign cpu_we    = cpu_wea && (state == S_RUN) && !cpu_hold;
   assign ram_we    = ld_we | cpu_we;
   assign ram_waddr = ld_we ? wptr : cpu_addr;
   assign ram_wdata = ld_we ? {hi, ld_byte} : cpu_wdata;

   sp_ram_rf #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (cpu_addr),
      .rdata (cpu_rdata)
   );

endmodule
